// File: rtl/alu_iter.sv
// alu_iter: iterative ALU with single-cycle arithmetic/logic/shift ops and a valid/ready handshake.
// Define ALU_ITER_MUL_EN to build the shift-add multiplier for op 1000; otherwise op 1000 passes a through.
module alu_iter #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             zero,
   output logic             ovfl,
   output logic             busy
);

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

`ifdef ALU_ITER_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t         state;
   logic           accept;
   logic [WIDTH:0] fn_res;

   // Single-cycle ops; returns {flag, result}. Shifts use the full b so large amounts saturate.
   function automatic logic [WIDTH:0] alu_fn(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [3:0]       f);
      logic signed [WIDTH-1:0] sx;
      logic        [WIDTH-1:0] rv;
      logic        [SHW-1:0]   sh;
      logic                    big;
      logic                    c;
      sx  = x;
      sh  = y[SHW-1:0];
      big = (y >= WIDTH_V);
      rv  = x;
      c   = 1'b0;
      case (f)
         4'b0000: {c, rv} = {1'b0, x} + {1'b0, y};
         4'b0001: {c, rv} = {1'b0, x} - {1'b0, y};
         4'b0010: rv = x | y;
         4'b0011: rv = x & y;
         4'b0100: rv = big ? '0 : x << sh;
         4'b0101: rv = big ? '0 : x >> sh;
         4'b0110: begin
            if (big) rv = {WIDTH{x[WIDTH-1]}};
            else     rv = sx >>> sh;
         end
         4'b0111: rv = y << (WIDTH / 2);
         default: rv = x;
      endcase
      return {c, rv};
   endfunction

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign fn_res   = alu_fn(a, b, op);

`ifdef ALU_ITER_MUL_EN
   localparam logic [3:0]     OP_MUL   = 4'b1000;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [SHW-1:0]     cnt;
   logic               busy_q;

   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   assign busy    = busy_q;
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r         <= '0;
         zero      <= 1'b1;
         ovfl      <= 1'b0;
         out_valid <= 1'b0;
`ifdef ALU_ITER_MUL_EN
         busy_q    <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
`endif
      end else begin
`ifdef ALU_ITER_MUL_EN
         // One multiplier bit per cycle; operands live in mcand/mplier so input changes cannot leak in.
         if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (cnt == CNT_LAST) begin
               state     <= DONE;
               busy_q    <= 1'b0;
               out_valid <= 1'b1;
               r         <= acc_nxt[WIDTH-1:0];
               zero      <= (acc_nxt[WIDTH-1:0] == '0);
               ovfl      <= |acc_nxt[2*WIDTH-1:WIDTH];
            end
         end else if (accept && op == OP_MUL) begin
            state     <= MUL;
            busy_q    <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, a};
            mplier    <= b;
            cnt       <= '0;
         end else
`endif
         if (accept) begin
            state     <= DONE;
            out_valid <= 1'b1;
            r         <= fn_res[WIDTH-1:0];
            zero      <= (fn_res[WIDTH-1:0] == '0);
            ovfl      <= fn_res[WIDTH];
         end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Randomized self-checking bench for alu_iter (WIDTH=16) against a transaction-level model.
module tb_alu_iter;

   localparam int W = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  r;
   logic          zero;
   logic          ovfl;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // model state: pending/visible result and remaining multiply cycles
   logic          mv;
   logic [W-1:0]  mr;
   logic          mo;
   logic [W-1:0]  pr;
   logic          po;
   int            mul_left;

   alu_iter #(.WIDTH(W), .SHW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .zero(zero), .ovfl(ovfl), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [3:0] f);
      logic [31:0]  t;
      logic [W-1:0] res;
      logic         c;
      c   = 1'b0;
      res = x;
      case (f)
         4'd0: begin t = 32'(x) + 32'(y); res = t[W-1:0]; c = (t > 32'h0000_FFFF); end
         4'd1: begin res = x - y; c = (x < y); end
         4'd2: res = x | y;
         4'd3: res = x & y;
         4'd4: res = (y >= 16) ? 16'h0000 : 16'(x << y);
         4'd5: res = (y >= 16) ? 16'h0000 : (x >> y);
         4'd6: begin
            if (y >= 16) res = x[W-1] ? 16'hFFFF : 16'h0000;
            else begin
               res = x >> y;
               if (x[W-1]) res = res | ~(16'hFFFF >> y);
            end
         end
         4'd7: res = 16'(y << 8);
`ifdef ALU_ITER_MUL_EN
         4'd8: begin t = 32'(x) * 32'(y); res = t[W-1:0]; c = (t[31:16] != 16'h0000); end
`endif
         default: res = x;
      endcase
      return {c, res};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mv       = 1'b0;
      mr       = '0;
      mo       = 1'b0;
      pr       = '0;
      po       = 1'b0;
      mul_left = 0;
   endtask

   // Called just after a negedge: pulses reset, checks the cleared outputs.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_ovfl", 32'(ovfl), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Drive one cycle, check in_ready, advance the model, then check registered outputs.
   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] iop, input logic ordy);
      logic       exp_rdy;
      logic       acc;
      logic [W:0] res;
      logic       is_mul;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      op        = iop;
      out_ready = ordy;
      #1;
      exp_rdy = (mul_left == 0) && (!mv || ordy);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = iv && exp_rdy;
      res = ref_op(ia, ib, iop);
`ifdef ALU_ITER_MUL_EN
      is_mul = (iop == 4'd8);
`else
      is_mul = 1'b0;
`endif
      if (mul_left > 0) begin
         mul_left--;
         if (mul_left == 0) begin
            mv = 1'b1;
            mr = pr;
            mo = po;
         end
      end else if (acc) begin
         if (is_mul) begin
            mul_left = W;
            mv       = 1'b0;
            pr       = res[W-1:0];
            po       = res[W];
         end else begin
            mv = 1'b1;
            mr = res[W-1:0];
            mo = res[W];
         end
      end else if (mv && ordy) begin
         mv = 1'b0;
      end
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("busy", 32'(busy), 32'(mul_left > 0));
      if (mv) begin
         chk("r", 32'(r), 32'(mr));
         chk("zero", 32'(zero), 32'(mr == '0));
         chk("ovfl", 32'(ovfl), 32'(mo));
      end
   endtask

   task automatic rnd_step();
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), rb, 4'($urandom),
           1'($urandom_range(0, 2) != 0));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // add with carry, then hold the result while the consumer stalls
      step(1'b1, 16'hFFFF, 16'h0001, 4'd0, 1'b0);
      chk("add_r", 32'(r), 32'h0000);
      chk("add_zero", 32'(zero), 32'd1);
      chk("add_ovfl", 32'(ovfl), 32'd1);
      chk("add_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h1111, 16'h2222, 4'd2, 1'b0);
         chk("stall_r", 32'(r), 32'h0000);
      end
      // release with a simultaneous request: no bubble
      step(1'b1, 16'h8004, 16'h0002, 4'd6, 1'b1);
      chk("sra_r", 32'(r), 32'hE001);
      chk("sra_valid", 32'(out_valid), 32'd1);
      step(1'b1, 16'h8000, 16'h0014, 4'd6, 1'b1);
      chk("sra_big_r", 32'(r), 32'hFFFF);
      step(1'b1, 16'h0001, 16'h0010, 4'd4, 1'b1);
      chk("shl_big_r", 32'(r), 32'h0000);
      chk("shl_big_zero", 32'(zero), 32'd1);
      step(1'b1, 16'h0003, 16'h0005, 4'd1, 1'b1);
      chk("sub_borrow", 32'(ovfl), 32'd1);
      chk("sub_r", 32'(r), 32'hFFFE);
      step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      chk("idle_valid", 32'(out_valid), 32'd0);

`ifdef ALU_ITER_MUL_EN
      step(1'b1, 16'h0100, 16'h0100, 4'd8, 1'b1);
      for (int i = 0; i < W - 1; i++) begin
         chk("mul_busy", 32'(busy), 32'd1);
         rnd_step();
      end
      chk("mul_busy_last", 32'(busy), 32'd1);
      rnd_step();
      chk("mul1_valid", 32'(out_valid), 32'd1);
      chk("mul1_r", 32'(r), 32'h0000);
      chk("mul1_ovfl", 32'(ovfl), 32'd1);
      chk("mul1_zero", 32'(zero), 32'd1);
      step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      step(1'b1, 16'h0003, 16'h0005, 4'd8, 1'b0);
      for (int i = 0; i < W; i++) rnd_step();
      chk("mul2_r", 32'(r), 32'h000F);
      chk("mul2_ovfl", 32'(ovfl), 32'd0);
      step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      // reset mid-multiply must discard the result
      step(1'b1, 16'h1234, 16'h5678, 4'd8, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      do_reset();
      for (int i = 0; i < W + 4; i++) step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      chk("abort_r", 32'(r), 32'h0000);
`else
      step(1'b1, 16'h1234, 16'h0007, 4'd8, 1'b0);
      chk("mulpass_r", 32'(r), 32'h1234);
      chk("mulpass_busy", 32'(busy), 32'd0);
      chk("mulpass_valid", 32'(out_valid), 32'd1);
      // reset while a result is waiting must discard it
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      chk("abort_r", 32'(r), 32'h0000);
`endif

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         rnd_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, even, >= 8.
REQ-002 SHALL have parameter SHW, default 4: shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  4  operation select.
REQ-010 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port r  output  WIDTH  result.
REQ-013 SHALL have port zero  output  1  r == 0.
REQ-014 SHALL have port ovfl  output  1  overflow/carry flag, per op.
REQ-015 SHALL have port busy  output  1  multiply in progress.

Function
REQ-016 SHALL implement states IDLE, MUL and DONE.
REQ-017 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-018 Accept SHALL be in_valid and in_ready; a, b and op SHALL be captured on accept.
REQ-019 On accept of a non-MUL op, the next state SHALL be DONE, with r/zero/ovfl registered in the same edge (latency 1).
REQ-020 Op map:
- 0000 add: ovfl = carry out.
- 0001 sub: ovfl = borrow (a < b unsigned).
- 0010 or.
- 0011 and.
- 0100 shl.
- 0101 shr (logical).
- 0110 sra (arithmetic, sign-fill).
- 0111 b << (WIDTH/2).
- 1000 mul.
- 1001-1111 r = a.
- ovfl SHALL be 0 for every op not listed with an ovfl rule.
REQ-021 Shift amount SHALL be the full b; if b >= WIDTH: shl/shr give 0, sra gives all bits = a[WIDTH-1].
REQ-022 mul SHALL be unsigned shift-add, one bit per cycle, WIDTH cycles in MUL, then DONE (latency WIDTH+1); r = low half of product, ovfl = (high half != 0).
REQ-023 busy SHALL be 1 exactly while state==MUL; in_ready SHALL be 0 in MUL.
REQ-024 DONE SHALL hold r/zero/ovfl/out_valid stable until out_ready; out_ready with no new accept SHALL go to IDLE and clear out_valid.
REQ-025 DONE with out_ready and a simultaneous accept SHALL load the new op with no bubble (back-to-back throughput 1/cycle for non-MUL ops).
REQ-026 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored when in_ready is 0.
REQ-027 Operand changes after accept SHALL NOT affect an in-flight result.

Reset
REQ-028 While rst_n = 0: state = IDLE; r = 0; zero = 1; ovfl = 0; out_valid = 0; busy = 0; in_ready = 1 after release.
REQ-029 Reset during MUL or DONE SHALL abort the operation and discard its result; no out_valid SHALL follow.

Configuration
REQ-030 Macro ALU_ITER_MUL_EN defined: op 1000 SHALL be multiply per REQ-022.
REQ-031 Macro ALU_ITER_MUL_EN undefined: op 1000 SHALL behave as r = a with latency 1; busy SHALL be constant 0; MUL state and multiplier logic SHALL be absent.

Verification (WIDTH=16)
REQ-032 add a=FFFF, b=0001 -> r=0000, zero=1, ovfl=1, out_valid one cycle after accept.
REQ-033 sra a=8004, b=0002 -> r=E001; sra a=8000, b=0014 -> r=FFFF; shl a=0001, b=0010 -> r=0000.
REQ-034 mul (MUL_EN) a=0100, b=0100 -> busy for 16 cycles, r=0000, ovfl=1, zero=1 at cycle 17; a=0003, b=0005 -> r=000F, ovfl=0.
REQ-035 out_ready held 0 for 5 cycles after a result -> r stable and in_ready=0 throughout; then out_ready=1 with in_valid=1 -> next op accepted in the same cycle, no bubble.
REQ-036 rst_n pulsed low mid-MUL at cycle 8 -> out_valid=0, r=0000, zero=1, in_ready=1 after release, no late result.
REQ-037 Build without MUL_EN, op=1000, a=1234 -> r=1234 after 1 cycle, busy never 1.
